// File: rtl/hs_arb_pkg.sv
// Shared types and helpers for the handshake round-robin arbiter.
// Holds the FSM encoding, index-width rule and round-robin pick.
package hs_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      REQ,
      ACK
   } state_t;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // First set bit scanning ptr, ptr+1, ... with explicit wrap at n.
   function automatic int rr_pick(
      input logic [31:0] req,
      input int          ptr,
      input int          n
   );
      int r;
      int idx;
      bit hit;
      r   = 0;
      hit = 1'b0;
      for (int i = 0; i < n; i++) begin
         idx = ptr + i;
         if (idx >= n) idx = idx - n;
         if (!hit && req[idx]) begin
            r   = idx;
            hit = 1'b1;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/hs_sync.sv
// Multi-flop synchronizer chain with synchronous clear.
// Brings asynchronous handshake wires into the clk domain.
module hs_sync #(
   parameter int W      = 1,
   parameter int STAGES = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] ff [STAGES];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < STAGES; i++) ff[i] <= '0;
      end else begin
         ff[0] <= d;
         for (int i = 1; i < STAGES; i++) ff[i] <= ff[i-1];
      end
   end

   assign q = ff[STAGES-1];

endmodule

// File: rtl/hs_rr_arbiter.sv
// Round-robin arbiter merging NREQ 4-phase bundled-data channels
// onto one 4-phase output channel, clocked with synchronized inputs.
module hs_rr_arbiter
   import hs_arb_pkg::*;
#(
   parameter int             N           = 1,
   parameter int             NREQ        = 2,
   parameter int             SYNC_STAGES = 2,
   parameter logic [N-1:0]   RdataVal    = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   r_i,
   output logic [NREQ-1:0]   a_i,
   input  logic [NREQ*N-1:0] d_i,
   output logic              r_o,
   input  logic              a_o,
   output logic [N-1:0]      d_o
);

   localparam int IW = idx_w(NREQ);

   logic [NREQ-1:0] rs;
   logic            ack_s;

   state_t          state, state_n;
   logic [IW-1:0]   ptr, ptr_n;
   logic [IW-1:0]   g, g_n;
   logic [N-1:0]    d_n;
   logic            r_n;
   logic [NREQ-1:0] a_n;
   int              win;

   hs_sync #(.W(NREQ), .STAGES(SYNC_STAGES)) u_sync_r (
      .clk (clk),
      .rst (rst),
      .d   (r_i),
      .q   (rs)
   );

   hs_sync #(.W(1), .STAGES(SYNC_STAGES)) u_sync_a (
      .clk (clk),
      .rst (rst),
      .d   (a_o),
      .q   (ack_s)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         ptr   <= '0;
         g     <= '0;
         d_o   <= RdataVal;
         r_o   <= 1'b0;
         a_i   <= '0;
      end else begin
         state <= state_n;
         ptr   <= ptr_n;
         g     <= g_n;
         d_o   <= d_n;
         r_o   <= r_n;
         a_i   <= a_n;
      end
   end

   // Data is captured on the grant edge so r_o rises a full cycle later.
   always_comb begin
      state_n = state;
      ptr_n   = ptr;
      g_n     = g;
      d_n     = d_o;
      r_n     = r_o;
      a_n     = a_i;
      win     = rr_pick(32'(rs), int'(ptr), NREQ);
      unique case (state)
         IDLE: begin
            if (!ack_s && |rs) begin
               state_n = LOAD;
               g_n     = IW'(win);
               d_n     = d_i[win*N +: N];
               ptr_n   = (win == NREQ - 1) ? '0 : IW'(win + 1);
            end
         end
         LOAD: begin
            state_n = REQ;
            r_n     = 1'b1;
         end
         REQ: begin
            if (ack_s) begin
               state_n = ACK;
               r_n     = 1'b0;
               a_n     = '0;
               a_n[g]  = 1'b1;
            end
         end
         ACK: begin
            if (!rs[g] && !ack_s) begin
               state_n = IDLE;
               a_n     = '0;
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_hs_rr_arbiter.sv
// Directed plus randomized bench for hs_rr_arbiter (N=8, NREQ=3).
// Expected grants come from a pending-set round-robin reference.
module tb_hs_rr_arbiter;

   localparam int          NR  = 3;
   localparam int          BUD = 40;
   localparam logic [7:0]  RV  = 8'h3C;

   logic          clk;
   logic          rst;
   logic [NR-1:0] r_i;
   logic [NR-1:0] a_i;
   logic [NR*8-1:0] d_i;
   logic          r_o;
   logic          a_o;
   logic [7:0]    d_o;

   int            total;
   int            bad;
   int            mptr;
   logic [NR-1:0] pend;
   logic [7:0]    data [NR];

   hs_rr_arbiter #(
      .N           (8),
      .NREQ        (NR),
      .SYNC_STAGES (2),
      .RdataVal    (RV)
   ) dut (
      .clk (clk),
      .rst (rst),
      .r_i (r_i),
      .a_i (a_i),
      .d_i (d_i),
      .r_o (r_o),
      .a_o (a_o),
      .d_o (d_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic raise(input int j, input logic [7:0] v);
      data[j]       = v;
      d_i[j*8 +: 8] = v;
      r_i[j]        = 1'b1;
      pend[j]       = 1'b1;
   endtask

   function automatic int pick();
      for (int i = 0; i < NR; i++)
         if (pend[(mptr + i) % NR]) return (mptr + i) % NR;
      return -1;
   endfunction

   task automatic wait_ro();
      int n;
      n = 0;
      while (r_o !== 1'b1 && n < BUD) begin
         step();
         n++;
      end
   endtask

   task automatic wait_ai(input bit high);
      int n;
      n = 0;
      while (((a_i !== '0) != high) && n < BUD) begin
         step();
         n++;
      end
   endtask

   task automatic xact(input int k, input bit rnd);
      wait_ro();
      chk("req_rise", 32'(r_o), 32'd1);
      chk("d_o_data", 32'(d_o), 32'(data[k]));
      a_o = 1'b1;
      wait_ai(1'b1);
      chk("grant", 32'(a_i), 32'(1 << k));
      chk("r_o_low", 32'(r_o), 32'd0);
      r_i[k]  = 1'b0;
      pend[k] = 1'b0;
      a_o     = 1'b0;
      if (rnd)
         for (int j = 0; j < NR; j++)
            if (j != k && !pend[j] && $urandom_range(0, 1) == 1)
               raise(j, 8'($urandom));
      wait_ai(1'b0);
      chk("ack_low", 32'(a_i), 32'd0);
      mptr = (k + 1) % NR;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst  = 1'b0;
      mptr = 0;
   endtask

   initial begin
      int k;
      total = 0;
      bad   = 0;
      pend  = '0;
      r_i   = '0;
      a_o   = 1'b0;
      d_i   = '0;
      for (int j = 0; j < NR; j++) data[j] = 8'h00;
      do_reset();
      chk("rst_r_o", 32'(r_o), 32'd0);
      chk("rst_a_i", 32'(a_i), 32'd0);
      chk("rst_d_o", 32'(d_o), 32'(RV));

      // single request latency: d_o at edge 3, r_o at edge 4
      raise(0, 8'hA5);
      step();
      step();
      chk("lat_d_o_e2", 32'(d_o), 32'(RV));
      step();
      chk("lat_d_o_e3", 32'(d_o), 32'hA5);
      chk("lat_r_o_e3", 32'(r_o), 32'd0);
      step();
      chk("lat_r_o_e4", 32'(r_o), 32'd1);
      xact(0, 1'b0);

      // output channel busy at reset blocks arbitration
      a_o = 1'b1;
      do_reset();
      raise(1, 8'h5A);
      for (int i = 0; i < 10; i++) step();
      chk("blk_r_o", 32'(r_o), 32'd0);
      chk("blk_d_o", 32'(d_o), 32'(RV));
      chk("blk_a_i", 32'(a_i), 32'd0);
      a_o = 1'b0;
      xact(1, 1'b0);

      // ptr=2: requests 0,2 -> 2, then wrap to 0
      raise(0, 8'h11);
      raise(2, 8'h22);
      chk("wrap_model1", 32'(pick()), 32'd2);
      xact(2, 1'b0);
      raise(2, 8'h33);
      chk("wrap_model2", 32'(pick()), 32'd0);
      xact(0, 1'b0);
      xact(2, 1'b0);

      // early request drop while REQ
      raise(1, 8'h77);
      wait_ro();
      r_i[1]  = 1'b0;
      pend[1] = 1'b0;
      raise(0, 8'h99);
      for (int i = 0; i < 6; i++) step();
      chk("drop_r_o", 32'(r_o), 32'd1);
      chk("drop_d_o", 32'(d_o), 32'h77);
      a_o = 1'b1;
      wait_ai(1'b1);
      chk("drop_grant", 32'(a_i), 32'd2);
      for (int i = 0; i < 6; i++) step();
      chk("drop_hold", 32'(a_i), 32'd2);
      chk("drop_no_req", 32'(r_o), 32'd0);
      a_o = 1'b0;
      wait_ai(1'b0);
      chk("drop_ack_low", 32'(a_i), 32'd0);
      mptr = 2;
      xact(0, 1'b0);

      // reset during REQ after a grant to 0 -> ptr back to 0
      raise(2, 8'h44);
      wait_ro();
      chk("mid_pre_r_o", 32'(r_o), 32'd1);
      r_i[2]  = 1'b0;
      pend[2] = 1'b0;
      rst = 1'b1;
      step();
      rst  = 1'b0;
      mptr = 0;
      chk("mid_r_o", 32'(r_o), 32'd0);
      chk("mid_a_i", 32'(a_i), 32'd0);
      chk("mid_d_o", 32'(d_o), 32'(RV));
      raise(1, 8'h61);
      raise(2, 8'h62);
      chk("mid_model", 32'(pick()), 32'd1);
      xact(1, 1'b0);
      xact(2, 1'b0);

      // randomized traffic against the pending-set model
      for (int it = 0; it < 40; it++) begin
         if (pend == '0) begin
            logic [NR-1:0] m;
            m = NR'($urandom_range(1, (1 << NR) - 1));
            for (int j = 0; j < NR; j++)
               if (m[j]) raise(j, 8'($urandom));
         end
         k = pick();
         xact(k, 1'b1);
         if ($urandom_range(0, 1) == 1) raise(k, 8'($urandom));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
